// File: rtl/intermediator_mem.sv
// intermediator_mem: true dual-port data RAM, XOR-banked occupancy bits and a small FIFO.
// Optional build macro INTERMEDIATOR_MEM_CHECK_EN enables the sticky FIFO misuse flag (err);
// without it err is tied to 0 and every other behaviour is the same.
module intermediator_mem #(
    parameter int DATA_WIDTH        = 66,
    parameter int RAM_DEPTH         = 1024,
    parameter int FIFO_WIDTH        = 76,
    parameter int FIFO_DEPTH        = 32,
    parameter int ALMOST_FULL_COUNT = 16,
    localparam int AW = $clog2(RAM_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_we0,
    input  logic                  ram_we1,
    input  logic [AW-1:0]         ram_addr0,
    input  logic [AW-1:0]         ram_addr1,
    input  logic [DATA_WIDTH-1:0] ram_d0,
    input  logic [DATA_WIDTH-1:0] ram_d1,
    output logic [DATA_WIDTH-1:0] ram_q0,
    output logic [DATA_WIDTH-1:0] ram_q1,
    input  logic                  occ_tgl0,
    input  logic                  occ_tgl1,
    input  logic [AW-1:0]         occ_addr0,
    input  logic [AW-1:0]         occ_addr1,
    output logic                  occ_q0,
    output logic                  occ_q1,
    input  logic                  fifo_push,
    input  logic                  fifo_pop,
    input  logic [FIFO_WIDTH-1:0] fifo_d,
    output logic [FIFO_WIDTH-1:0] fifo_q,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_empty,
    output logic                  fifo_almost_full,
    output logic [CW-1:0]         fifo_count,
    output logic                  err
);

    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL_COUNT);

    logic [DATA_WIDTH-1:0] ram_mem [RAM_DEPTH];
    logic [RAM_DEPTH-1:0]  occ_bank0;
    logic [RAM_DEPTH-1:0]  occ_bank1;
    logic [FIFO_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    // Data RAM: both ports read-first with registered output; port 1's write lands last so it wins a collision
    always_ff @(posedge clk) begin
        ram_q0 <= ram_mem[ram_addr0];
        ram_q1 <= ram_mem[ram_addr1];
        if (ram_we0) begin
            ram_mem[ram_addr0] <= ram_d0;
        end
        if (ram_we1) begin
            ram_mem[ram_addr1] <= ram_d1;
        end
    end

    // Occupancy banks: each port owns one bank so a same-address double toggle cancels in the XOR
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_bank0 <= '0;
            occ_bank1 <= '0;
        end else begin
            if (occ_tgl0) begin
                occ_bank0[occ_addr0] <= ~occ_bank0[occ_addr0];
            end
            if (occ_tgl1) begin
                occ_bank1[occ_addr1] <= ~occ_bank1[occ_addr1];
            end
        end
    end

    assign occ_q0 = occ_bank0[occ_addr0] ^ occ_bank1[occ_addr0];
    assign occ_q1 = occ_bank0[occ_addr1] ^ occ_bank1[occ_addr1];

    // A pop needs data; a push needs room, or room freed by a pop in the same cycle
    assign pop_ok  = fifo_pop && !fifo_empty;
    assign push_ok = fifo_push && (!fifo_full || pop_ok);

    // FIFO storage is not reset; only pointers and count define which words are live
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            fifo_mem[wr_ptr] <= fifo_d;
        end
    end

    // FIFO pointers, occupancy count and registered head word
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            fifo_q     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
                fifo_q <= fifo_mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign fifo_full         = (fifo_count == FULL_COUNT);
    assign fifo_empty        = (fifo_count == '0);
    assign fifo_almost_empty = (fifo_count <= CW'(1));
    assign fifo_almost_full  = (fifo_count >= AF_COUNT);

`ifdef INTERMEDIATOR_MEM_CHECK_EN
    // Sticky misuse flag: a refused push or a pop from an empty FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((fifo_push && !push_ok) || (fifo_pop && !pop_ok)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_intermediator_mem.sv
// tb_intermediator_mem: scoreboard bench for intermediator_mem with a queue/array reference model.
// Honours INTERMEDIATOR_MEM_CHECK_EN the same way as the design (err expectation).
module tb_intermediator_mem;

    localparam int DW  = 66;
    localparam int RD  = 1024;
    localparam int FW  = 76;
    localparam int FD  = 32;
    localparam int AFC = 16;
    localparam int AW  = 10;
    localparam int CW  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          ram_we0, ram_we1;
    logic [AW-1:0] ram_addr0, ram_addr1;
    logic [DW-1:0] ram_d0, ram_d1;
    logic [DW-1:0] ram_q0, ram_q1;
    logic          occ_tgl0, occ_tgl1;
    logic [AW-1:0] occ_addr0, occ_addr1;
    logic          occ_q0, occ_q1;
    logic          fifo_push, fifo_pop;
    logic [FW-1:0] fifo_d, fifo_q;
    logic          fifo_full, fifo_empty, fifo_almost_empty, fifo_almost_full;
    logic [CW-1:0] fifo_count;
    logic          err;

    always #5 clk = ~clk;

    intermediator_mem dut (
        .clk(clk), .rst(rst),
        .ram_we0(ram_we0), .ram_we1(ram_we1),
        .ram_addr0(ram_addr0), .ram_addr1(ram_addr1),
        .ram_d0(ram_d0), .ram_d1(ram_d1),
        .ram_q0(ram_q0), .ram_q1(ram_q1),
        .occ_tgl0(occ_tgl0), .occ_tgl1(occ_tgl1),
        .occ_addr0(occ_addr0), .occ_addr1(occ_addr1),
        .occ_q0(occ_q0), .occ_q1(occ_q1),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop),
        .fifo_d(fifo_d), .fifo_q(fifo_q),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_almost_empty(fifo_almost_empty), .fifo_almost_full(fifo_almost_full),
        .fifo_count(fifo_count), .err(err)
    );

    typedef struct {
        logic          rst;
        logic          we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          t0;
        logic [AW-1:0] o0;
        logic          t1;
        logic [AW-1:0] o1;
        logic          push;
        logic          pop;
        logic [FW-1:0] fd;
    } stim_t;

    typedef struct {
        bit            chkRam0;
        logic [DW-1:0] ram0;
        bit            chkRam1;
        logic [DW-1:0] ram1;
        bit            chkOccPre;
        bit            occPre0;
        bit            occPre1;
        bit            chkOccPost;
        bit            occPost0;
        bit            occPost1;
        int            count;
        bit            err;
    } exp_t;

    logic [DW-1:0] ramModel [int];
    bit   [RD-1:0] occModel;
    bit            occKnown = 1'b0;
    logic [FW-1:0] fifoModel [$];
    logic [FW-1:0] fifoExpQ [$];
    exp_t          expQ [$];
    bit            errModel = 1'b0;
    int            checks = 0;
    int            failures = 0;

    // One comparison: counted, and reported with actual and required values on mismatch
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.we0 = 1'b0; s.a0 = '0; s.d0 = '0;
        s.we1 = 1'b0; s.a1 = '0; s.d1 = '0;
        s.t0 = 1'b0; s.o0 = '0; s.t1 = 1'b0; s.o1 = '0;
        s.push = 1'b0; s.pop = 1'b0; s.fd = '0;
        return s;
    endfunction

    // Drive one cycle of inputs and record what the next edge must produce
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   popAcc, pushAcc;
        @(negedge clk);
        rst = s.rst;
        ram_we0 = s.we0; ram_addr0 = s.a0; ram_d0 = s.d0;
        ram_we1 = s.we1; ram_addr1 = s.a1; ram_d1 = s.d1;
        occ_tgl0 = s.t0; occ_addr0 = s.o0; occ_tgl1 = s.t1; occ_addr1 = s.o1;
        fifo_push = s.push; fifo_pop = s.pop; fifo_d = s.fd;

        e.chkRam0 = ramModel.exists(int'(s.a0));
        e.ram0    = e.chkRam0 ? ramModel[int'(s.a0)] : '0;
        e.chkRam1 = ramModel.exists(int'(s.a1));
        e.ram1    = e.chkRam1 ? ramModel[int'(s.a1)] : '0;
        if (s.we0) ramModel[int'(s.a0)] = s.d0;
        if (s.we1) ramModel[int'(s.a1)] = s.d1;

        e.chkOccPre = occKnown;
        e.occPre0   = occModel[s.o0];
        e.occPre1   = occModel[s.o1];
        if (s.rst) begin
            occModel = '0;
            occKnown = 1'b1;
        end else begin
            if (s.t0) occModel[s.o0] = !occModel[s.o0];
            if (s.t1) occModel[s.o1] = !occModel[s.o1];
        end
        e.chkOccPost = occKnown;
        e.occPost0   = occModel[s.o0];
        e.occPost1   = occModel[s.o1];

        if (s.rst) begin
            fifoModel.delete();
            errModel = 1'b0;
        end else begin
            popAcc  = s.pop && (fifoModel.size() > 0);
            pushAcc = s.push && ((fifoModel.size() < FD) || popAcc);
            if (popAcc) fifoExpQ.push_back(fifoModel.pop_front());
            if (pushAcc) fifoModel.push_back(s.fd);
`ifdef INTERMEDIATOR_MEM_CHECK_EN
            if ((s.push && !pushAcc) || (s.pop && !popAcc)) errModel = 1'b1;
`endif
        end
        e.count = fifoModel.size();
        e.err   = errModel;
        expQ.push_back(e);
    endtask

    // Monitor: pre-edge combinational checks, then post-edge checks; fifo_q follows observed pop handshakes
    initial begin : monitor
        exp_t          e;
        bit            hs;
        bit            inRst;
        logic [FW-1:0] held;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0) continue;
            e = expQ[0];
            hs    = (fifo_pop === 1'b1) && (fifo_empty === 1'b0) && (rst === 1'b0);
            inRst = (rst === 1'b1);
            if (e.chkOccPre) begin
                checkOutput("occ_q0_pre", 128'(occ_q0), 128'(e.occPre0));
                checkOutput("occ_q1_pre", 128'(occ_q1), 128'(e.occPre1));
            end
            @(posedge clk);
            #1;
            e = expQ.pop_front();
            if (inRst) begin
                held = '0;
            end else if (hs) begin
                if (fifoExpQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL fifo_pop_unexpected actual=accepted required=refused at %0t", $time);
                end else begin
                    held = fifoExpQ.pop_front();
                end
            end
            if (e.chkRam0) checkOutput("ram_q0", 128'(ram_q0), 128'(e.ram0));
            if (e.chkRam1) checkOutput("ram_q1", 128'(ram_q1), 128'(e.ram1));
            if (e.chkOccPost) begin
                checkOutput("occ_q0", 128'(occ_q0), 128'(e.occPost0));
                checkOutput("occ_q1", 128'(occ_q1), 128'(e.occPost1));
            end
            checkOutput("fifo_q", 128'(fifo_q), 128'(held));
            checkOutput("fifo_count", 128'(fifo_count), 128'(e.count));
            checkOutput("fifo_full", 128'(fifo_full), 128'(e.count == FD));
            checkOutput("fifo_empty", 128'(fifo_empty), 128'(e.count == 0));
            checkOutput("fifo_almost_empty", 128'(fifo_almost_empty), 128'(e.count <= 1));
            checkOutput("fifo_almost_full", 128'(fifo_almost_full), 128'(e.count >= AFC));
            checkOutput("err", 128'(err), 128'(e.err));
        end
    end

    // Watchdog so the run always ends
    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by randomized traffic
    initial begin : stimulus
        stim_t s;
        int    bias;
        rst = 1'b1;
        ram_we0 = 1'b0; ram_we1 = 1'b0; ram_addr0 = '0; ram_addr1 = '0;
        ram_d0 = '0; ram_d1 = '0;
        occ_tgl0 = 1'b0; occ_tgl1 = 1'b0; occ_addr0 = '0; occ_addr1 = '0;
        fifo_push = 1'b0; fifo_pop = 1'b0; fifo_d = '0;

        s = idle(); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        $display("[TB] data RAM cross-port read");
        s = idle(); s.we0 = 1'b1; s.a0 = AW'(5); s.d0 = 66'h3_FFFF_0000_1234;
        applyStimulus(s);
        s = idle(); s.a1 = AW'(5); s.a0 = AW'(5);
        applyStimulus(s);
        s = idle(); s.we0 = 1'b1; s.a0 = AW'(9); s.d0 = DW'(66'h111);
        s.we1 = 1'b1; s.a1 = AW'(9); s.d1 = DW'(66'h222);
        applyStimulus(s);
        s = idle(); s.a0 = AW'(9); s.a1 = AW'(9); s.we0 = 1'b1; s.d0 = DW'(66'h333);
        applyStimulus(s);
        s = idle(); s.a0 = AW'(9); s.a1 = AW'(5);
        applyStimulus(s);

        $display("[TB] occupancy toggles");
        s = idle(); s.o0 = AW'(7); s.o1 = AW'(3);
        applyStimulus(s);
        s.t0 = 1'b1;
        applyStimulus(s);
        s = idle(); s.o0 = AW'(7); s.o1 = AW'(7); s.t1 = 1'b1;
        applyStimulus(s);
        s = idle(); s.o0 = AW'(3); s.o1 = AW'(3); s.t0 = 1'b1; s.t1 = 1'b1;
        applyStimulus(s);
        s = idle(); s.o0 = AW'(3); s.o1 = AW'(7);
        applyStimulus(s);

        $display("[TB] FIFO fill and drain");
        for (int i = 0; i < FD + 1; i++) begin
            s = idle(); s.push = 1'b1; s.fd = FW'(i);
            applyStimulus(s);
        end
        s = idle(); s.push = 1'b1; s.pop = 1'b1; s.fd = FW'(100);
        applyStimulus(s);
        for (int i = 0; i < FD + 1; i++) begin
            s = idle(); s.pop = 1'b1;
            applyStimulus(s);
        end
        s = idle(); s.push = 1'b1; s.pop = 1'b1; s.fd = FW'(55);
        applyStimulus(s);

        $display("[TB] reset with words queued");
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.push = 1'b1; s.fd = FW'(200 + i);
            s.t0 = 1'b1; s.o0 = AW'(i); s.o1 = AW'(i);
            applyStimulus(s);
        end
        s = idle(); s.rst = 1'b1; s.push = 1'b1; s.t0 = 1'b1; s.o0 = AW'(2);
        applyStimulus(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.o0 = AW'(i); s.o1 = AW'(i + 5);
            applyStimulus(s);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            bias = ((i / 60) % 2 == 0) ? 80 : 20;
            s = idle();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.we0  = $urandom_range(0, 1);
            s.a0   = AW'($urandom_range(0, 15));
            s.d0   = DW'({$urandom, $urandom, $urandom});
            s.we1  = $urandom_range(0, 1);
            s.a1   = AW'($urandom_range(0, 15));
            s.d1   = DW'({$urandom, $urandom, $urandom});
            s.t0   = $urandom_range(0, 1);
            s.o0   = AW'($urandom_range(0, 7));
            s.t1   = $urandom_range(0, 1);
            s.o1   = AW'($urandom_range(0, 7));
            s.push = ($urandom_range(0, 99) < bias);
            s.pop  = ($urandom_range(0, 99) >= bias);
            s.fd   = FW'({$urandom, $urandom, $urandom});
            applyStimulus(s);
        end

        s = idle();
        applyStimulus(s);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 128'(expQ.size()), 128'(0));
        checkOutput("fifo_pops_all_seen", 128'(fifoExpQ.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
